// File: rtl/mem_access_stage_pkg.sv
// Shared types for the memory-access pipeline stage: memory modes, FSM states
// and the captured instruction bundle.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    MM_NONE = 2'b00,
    MM_WORD = 2'b01,
    MM_BYTE = 2'b10,
    MM_RSVD = 2'b11
  } mm_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } ms_state_t;

  typedef struct packed {
    logic wbs;
    logic ni;
    logic wce;
    logic wme1;
    logic wme2;
    logic reg_dest;
    logic wre;
  } ctrl_t;

  typedef struct packed {
    ctrl_t       ctrl;
    mm_t         mm;
    logic        wm;
    logic [15:0] alu;
    logic [15:0] data;
    logic [3:0]  dest;
  } bundle_t;

  function automatic int cnt_width(input int timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack port; the stage is master, the memory is slave.
interface mem_bus_if;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_be;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_stage_lane_align.sv
// Byte-lane steering for stores and lane select / zero-extension for loads.
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  mm_t         mode_i,
  input  logic        a0_i,
  input  logic [15:0] wdata_i,
  input  logic [15:0] rdata_i,
  output logic [1:0]  be_o,
  output logic [15:0] wdata_o,
  output logic [15:0] rdata_o
);

  always_comb begin
    be_o    = 2'b00;
    wdata_o = 16'h0000;
    rdata_o = 16'h0000;
    case (mode_i)
      MM_WORD: begin
        be_o    = 2'b11;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
      MM_BYTE: begin
        be_o    = a0_i ? 2'b10 : 2'b01;
        wdata_o = {wdata_i[7:0], wdata_i[7:0]};
        rdata_o = {8'h00, (a0_i ? rdata_i[15:8] : rdata_i[7:0])};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: issues the data access, stalls upstream while it is
// outstanding, aborts on timeout and registers the writeback bundle.
//
// state | meaning
// IDLE  | accepting a new bundle; non-memory ops retire next edge
// WAIT  | request outstanding, upstream stalled, timeout counter running
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             wbs_in,
  input  logic             ni_in,
  input  logic             wce_in,
  input  logic             wme1_in,
  input  logic             wme2_in,
  input  logic             reg_dest_in,
  input  logic             wre_in,
  input  logic [1:0]       mm_in,
  input  logic             wm_in,
  input  logic [15:0]      ALUresult_in,
  input  logic [15:0]      memData_in,
  input  logic [3:0]       reg_dest_data_writeback_in,
  mem_bus_if.master        mem,
  output logic             stall_o,
  output logic             wb_valid,
  output logic             wbs_out,
  output logic             ni_out,
  output logic             wce_out,
  output logic             wme1_out,
  output logic             wme2_out,
  output logic             reg_dest_out,
  output logic             wre_out,
  output logic [15:0]      ALUresult_out,
  output logic [15:0]      memData_out,
  output logic [3:0]       reg_dest_data_writeback_out,
  output logic             timeout_err
);

  localparam int CW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  ms_state_t   state_q;
  bundle_t     in_b;
  bundle_t     cap_q;
  ctrl_t       ctrl_out_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        mem_req_q;
  logic        wb_valid_q;
  logic        timeout_err_q;
  logic [15:0] alu_out_q;
  logic [15:0] mdata_out_q;
  logic [3:0]  dest_out_q;
  logic [15:0] rdata_fmt;
  logic        in_is_mem;

  always_comb begin
    in_b.ctrl.wbs      = wbs_in;
    in_b.ctrl.ni       = ni_in;
    in_b.ctrl.wce      = wce_in;
    in_b.ctrl.wme1     = wme1_in;
    in_b.ctrl.wme2     = wme2_in;
    in_b.ctrl.reg_dest = reg_dest_in;
    in_b.ctrl.wre      = wre_in;
    in_b.mm            = mm_t'(mm_in);
    in_b.wm            = wm_in;
    in_b.alu           = ALUresult_in;
    in_b.data          = memData_in;
    in_b.dest          = reg_dest_data_writeback_in;
  end

  assign in_is_mem = (in_b.mm == MM_WORD) || (in_b.mm == MM_BYTE);
  assign cnt_d     = cnt_q + 1'b1;

  // Bus fields come straight from the capture, so they are stable for the
  // whole request and read as zero after reset.
  mem_lane_align u_lane_align (
    .mode_i  (cap_q.mm),
    .a0_i    (cap_q.alu[0]),
    .wdata_i (cap_q.data),
    .rdata_i (mem.mem_rdata),
    .be_o    (mem.mem_be),
    .wdata_o (mem.mem_wdata),
    .rdata_o (rdata_fmt)
  );

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_we   = cap_q.wm;
  assign mem.mem_addr = {cap_q.alu[15:1], 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cap_q         <= '0;
      ctrl_out_q    <= '0;
      cnt_q         <= '0;
      mem_req_q     <= 1'b0;
      wb_valid_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      alu_out_q     <= '0;
      mdata_out_q   <= '0;
      dest_out_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          wb_valid_q <= 1'b0;
          if (in_valid) begin
            if (in_is_mem) begin
              cap_q     <= in_b;
              cnt_q     <= '0;
              mem_req_q <= 1'b1;
              state_q   <= WAIT;
            end else begin
              wb_valid_q  <= 1'b1;
              ctrl_out_q  <= in_b.ctrl;
              alu_out_q   <= in_b.alu;
              dest_out_q  <= in_b.dest;
              mdata_out_q <= '0;
            end
          end
        end
        WAIT: begin
          if (mem.mem_ack) begin
            mem_req_q   <= 1'b0;
            state_q     <= IDLE;
            wb_valid_q  <= 1'b1;
            ctrl_out_q  <= cap_q.ctrl;
            alu_out_q   <= cap_q.alu;
            dest_out_q  <= cap_q.dest;
            mdata_out_q <= cap_q.wm ? 16'h0000 : rdata_fmt;
          end else if (cnt_q == CNT_LAST) begin
            // Aborted access still retires, but must not write the register file.
            mem_req_q      <= 1'b0;
            state_q        <= IDLE;
            timeout_err_q  <= 1'b1;
            wb_valid_q     <= 1'b1;
            ctrl_out_q     <= cap_q.ctrl;
            ctrl_out_q.wre <= 1'b0;
            alu_out_q      <= cap_q.alu;
            dest_out_q     <= cap_q.dest;
            mdata_out_q    <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall_o                     = (state_q == WAIT);
  assign wb_valid                    = wb_valid_q;
  assign wbs_out                     = ctrl_out_q.wbs;
  assign ni_out                      = ctrl_out_q.ni;
  assign wce_out                     = ctrl_out_q.wce;
  assign wme1_out                    = ctrl_out_q.wme1;
  assign wme2_out                    = ctrl_out_q.wme2;
  assign reg_dest_out                = ctrl_out_q.reg_dest;
  assign wre_out                     = ctrl_out_q.wre;
  assign ALUresult_out               = alu_out_q;
  assign memData_out                 = mdata_out_q;
  assign reg_dest_data_writeback_out = dest_out_q;
  assign timeout_err                 = timeout_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage with a short timeout so the abort path
// is reachable quickly.
module tb_mem_access_stage;

  localparam int T_CYC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        wbs_in = 1'b0, ni_in = 1'b0, wce_in = 1'b0, wme1_in = 1'b0;
  logic        wme2_in = 1'b0, reg_dest_in = 1'b0, wre_in = 1'b0;
  logic [1:0]  mm_in = 2'b00;
  logic        wm_in = 1'b0;
  logic [15:0] ALUresult_in = '0;
  logic [15:0] memData_in = '0;
  logic [3:0]  reg_dest_data_writeback_in = '0;
  logic        stall_o, wb_valid;
  logic        wbs_out, ni_out, wce_out, wme1_out, wme2_out, reg_dest_out, wre_out;
  logic [15:0] ALUresult_out, memData_out;
  logic [3:0]  reg_dest_data_writeback_out;
  logic        timeout_err;

  mem_bus_if mem_bus ();

  mem_access_stage #(.TIMEOUT_CYCLES(T_CYC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .wbs_in(wbs_in), .ni_in(ni_in), .wce_in(wce_in), .wme1_in(wme1_in),
    .wme2_in(wme2_in), .reg_dest_in(reg_dest_in), .wre_in(wre_in),
    .mm_in(mm_in), .wm_in(wm_in), .ALUresult_in(ALUresult_in),
    .memData_in(memData_in),
    .reg_dest_data_writeback_in(reg_dest_data_writeback_in),
    .mem(mem_bus),
    .stall_o(stall_o), .wb_valid(wb_valid),
    .wbs_out(wbs_out), .ni_out(ni_out), .wce_out(wce_out), .wme1_out(wme1_out),
    .wme2_out(wme2_out), .reg_dest_out(reg_dest_out), .wre_out(wre_out),
    .ALUresult_out(ALUresult_out), .memData_out(memData_out),
    .reg_dest_data_writeback_out(reg_dest_data_writeback_out),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [42:0] exp_q[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // {ctrl[6:0] (wbs..wre), dest, alu, mdata}
  function automatic logic [42:0] mk_exp(input logic [6:0] ctrl, input logic [3:0] dest,
                                         input logic [15:0] alu, input logic [15:0] md);
    return {ctrl, dest, alu, md};
  endfunction

  always @(negedge clk) begin
    if (wb_valid) begin
      if (exp_q.size() == 0) check_val("wb_unexpected", 64'd1, 64'd0);
      else check_val("wb_bundle",
                     {21'd0, wbs_out, ni_out, wce_out, wme1_out, wme2_out, reg_dest_out,
                      wre_out, reg_dest_data_writeback_out, ALUresult_out, memData_out},
                     {21'd0, exp_q.pop_front()});
    end
  end

  task automatic drive_instr(input logic [1:0] mm, input logic wm, input logic [15:0] alu,
                             input logic [15:0] data, input logic [3:0] dest,
                             input logic [6:0] ctrl);
    {wbs_in, ni_in, wce_in, wme1_in, wme2_in, reg_dest_in, wre_in} = ctrl;
    mm_in = mm; wm_in = wm; ALUresult_in = alu; memData_in = data;
    reg_dest_data_writeback_in = dest;
    in_valid = 1'b1;
    @(negedge clk);
    check_val("stall_accept", stall_o, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Called one step after the accept edge; cycle k=1 is the first WAIT cycle.
  task automatic run_mem(input int ack_cycle, input logic [15:0] rd,
                         output int stall_n, output int req_n, output int wb_k);
    stall_n = 0; req_n = 0; wb_k = 0;
    for (int k = 1; k <= 10; k++) begin
      mem_bus.mem_ack   = (k == ack_cycle);
      mem_bus.mem_rdata = rd;
      @(negedge clk);
      if (stall_o) stall_n++;
      if (mem_bus.mem_req) req_n++;
      if (wb_valid && wb_k == 0) wb_k = k;
      @(posedge clk); #1;
      mem_bus.mem_ack = 1'b0;
    end
  endtask

  initial begin
    int st, rq, wk;
    mem_bus.mem_ack = 1'b0;
    mem_bus.mem_rdata = 16'h0000;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_ctrl", {wb_valid, mem_bus.mem_req, stall_o, timeout_err, mem_bus.mem_we}, 0);
    check_val("rst_bus", {mem_bus.mem_be, mem_bus.mem_addr, mem_bus.mem_wdata}, 0);
    check_val("rst_bundle", {wbs_out, ni_out, wce_out, wme1_out, wme2_out, reg_dest_out,
                             wre_out, reg_dest_data_writeback_out, ALUresult_out, memData_out}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ALU op
    exp_q.push_back(mk_exp(7'b1010011, 4'd5, 16'h1234, 16'h0000));
    drive_instr(2'b00, 1'b0, 16'h1234, 16'hAAAA, 4'd5, 7'b1010011);
    @(negedge clk);
    check_val("alu_wb_valid", wb_valid, 1);
    check_val("alu_stall", stall_o, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("idle_wb_valid", wb_valid, 0);
    check_val("idle_hold_alu", ALUresult_out, 16'h1234);
    @(posedge clk); #1;

    // Word load, ack in third WAIT cycle
    exp_q.push_back(mk_exp(7'b0100101, 4'd3, 16'h0011, 16'hBEEF));
    drive_instr(2'b01, 1'b0, 16'h0011, 16'h5555, 4'd3, 7'b0100101);
    check_val("wl_req", mem_bus.mem_req, 1);
    check_val("wl_addr", mem_bus.mem_addr, 16'h0010);
    check_val("wl_be", mem_bus.mem_be, 2'b11);
    check_val("wl_we", mem_bus.mem_we, 0);
    run_mem(3, 16'hBEEF, st, rq, wk);
    check_val("wl_stall_cycles", st, 3);
    check_val("wl_req_cycles", rq, 3);
    check_val("wl_latency", wk, 4);

    // Byte store, upper lane
    exp_q.push_back(mk_exp(7'b0001000, 4'd9, 16'h0021, 16'h0000));
    drive_instr(2'b10, 1'b1, 16'h0021, 16'h00A5, 4'd9, 7'b0001000);
    check_val("bs_addr", mem_bus.mem_addr, 16'h0020);
    check_val("bs_be", mem_bus.mem_be, 2'b10);
    check_val("bs_wdata", mem_bus.mem_wdata, 16'hA5A5);
    check_val("bs_we", mem_bus.mem_we, 1);
    run_mem(2, 16'h1111, st, rq, wk);
    check_val("bs_latency", wk, 3);

    // Byte load, lower lane, immediate ack
    exp_q.push_back(mk_exp(7'b1000001, 4'd7, 16'h0020, 16'h0080));
    drive_instr(2'b10, 1'b0, 16'h0020, 16'h0000, 4'd7, 7'b1000001);
    check_val("bl_be", mem_bus.mem_be, 2'b01);
    run_mem(1, 16'h7F80, st, rq, wk);
    check_val("bl_latency", wk, 2);
    check_val("bl_stall_cycles", st, 1);

    // Reserved mode behaves as a non-memory op
    exp_q.push_back(mk_exp(7'b0110001, 4'd2, 16'hC0DE, 16'h0000));
    drive_instr(2'b11, 1'b1, 16'hC0DE, 16'h4321, 4'd2, 7'b0110001);
    @(negedge clk);
    check_val("rsvd_wb_valid", wb_valid, 1);
    check_val("rsvd_req", mem_bus.mem_req, 0);
    @(posedge clk); #1;

    // Stray ack in IDLE
    mem_bus.mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_bus.mem_ack = 1'b0;
    @(negedge clk);
    check_val("idle_ack_req", {mem_bus.mem_req, stall_o, wb_valid}, 0);
    @(posedge clk); #1;

    // Timeout, late ack ignored
    check_val("pre_timeout_err", timeout_err, 0);
    exp_q.push_back(mk_exp(7'b1111110, 4'd12, 16'h0100, 16'h0000));
    drive_instr(2'b01, 1'b0, 16'h0100, 16'h0000, 4'd12, 7'b1111111);
    run_mem(8, 16'hDEAD, st, rq, wk);
    check_val("to_req_cycles", rq, T_CYC);
    check_val("to_stall_cycles", st, T_CYC);
    check_val("to_latency", wk, T_CYC + 1);
    check_val("to_err_sticky", timeout_err, 1);

    // Reset while waiting
    drive_instr(2'b01, 1'b1, 16'h0040, 16'h9999, 4'd1, 7'b0000001);
    check_val("rw_req", mem_bus.mem_req, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("rw_after", {mem_bus.mem_req, stall_o, wb_valid, timeout_err}, 0);
    check_val("rw_alu_out", ALUresult_out, 0);
    exp_q.push_back(mk_exp(7'b0000011, 4'd4, 16'h0F0F, 16'h0000));
    drive_instr(2'b00, 1'b0, 16'h0F0F, 16'h0000, 4'd4, 7'b0000011);
    @(negedge clk);
    check_val("rw_alu_wb_valid", wb_valid, 1);
    repeat (3) @(posedge clk);
    #1;

    check_val("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
